// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states,
// instruction field positions and flag indices.
package rf_seq_pkg;

  localparam int RF_W = 4;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_JZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam int OPC_HI   = 7;
  localparam int OPC_LO   = 5;
  localparam int DST_BIT  = 4;
  localparam int SRCA_BIT = 3;
  localparam int SRCB_BIT = 2;
  localparam int IMM_HI   = 3;
  localparam int IMM_LO   = 0;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage

// File: rtl/rf_sequencer_if.sv
// Bus between the sequencer, the program ROM and the two-entry register file.
interface rf_sequencer_if #(
  parameter int ADDR_W = 4
);
  import rf_seq_pkg::*;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              rf_sa;
  logic              rf_sb;
  logic              rf_da;
  logic              rf_w;
  logic [RF_W-1:0]   rf_d;
  logic [RF_W-1:0]   rf_a;
  logic [RF_W-1:0]   rf_b;

  modport master (
    output rom_en, rom_addr, rf_sa, rf_sb, rf_da, rf_w, rf_d,
    input  rom_data, rf_a, rf_b
  );

  modport slave (
    input  rom_en, rom_addr, rf_sa, rf_sb, rf_da, rf_w, rf_d,
    output rom_data, rf_a, rf_b
  );

endinterface

// File: rtl/rf_alu.sv
// 4-bit add/subtract with carry (add) or borrow (sub) and a zero detect.
module rf_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = RF_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] ext;

  // One extra bit of width: its top bit is the add carry or the subtract borrow (A<B)
  always_comb begin
    if (sub) ext = {1'b0, a} - {1'b0, b};
    else     ext = {1'b0, a} + {1'b0, b};
    result = ext[DATA_W-1:0];
    carry  = ext[DATA_W];
    zero   = (ext[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/rf_sequencer.sv
// Control unit: fetches instructions from a synchronous ROM, decodes them and
// drives the register-file ports; 3 cycles per instruction (FETCH/LOAD/EXEC).
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  rf_sequencer_if.master bus,
  output logic          zero_flag,
  output logic          carry_flag,
  output logic          busy,
  output logic          halted
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        ir_q;
  logic [1:0]        flags_q;

  logic              load_ir, pc_clear, pc_jump;
  logic              flags_clear, z_we, c_we, z_d, c_d;
  logic [2:0]        opcode;
  logic [3:0]        imm;
  logic [RF_W-1:0]   alu_res;
  logic              alu_carry, alu_zero, alu_sub;

  assign opcode     = ir_q[OPC_HI:OPC_LO];
  assign imm        = ir_q[IMM_HI:IMM_LO];
  assign alu_sub    = (opcode == OP_SUB);
  assign zero_flag  = flags_q[FLAG_Z];
  assign carry_flag = flags_q[FLAG_C];

  rf_alu #(.DATA_W(RF_W)) u_alu (
    .a      (bus.rf_a),
    .b      (bus.rf_b),
    .sub    (alu_sub),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // FSM state register; reset drops straight to IDLE so all decoded outputs clear at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // PC, instruction register and flags; a taken jump overrides the LOAD increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      if (load_ir) ir_q <= bus.rom_data;
      if (pc_clear)     pc_q <= '0;
      else if (pc_jump) pc_q <= ADDR_W'(imm);
      else if (load_ir) pc_q <= pc_q + ADDR_W'(1);
      if (flags_clear) flags_q <= '0;
      if (z_we) flags_q[FLAG_Z] <= z_d;
      if (c_we) flags_q[FLAG_C] <= c_d;
    end
  end

  // Next-state logic and decode; RF lines are only driven while in EXEC
  always_comb begin
    state_d      = state_q;
    load_ir      = 1'b0;
    pc_clear     = 1'b0;
    pc_jump      = 1'b0;
    flags_clear  = 1'b0;
    z_we         = 1'b0;
    c_we         = 1'b0;
    z_d          = 1'b0;
    c_d          = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    bus.rom_en   = 1'b0;
    bus.rom_addr = pc_q;
    bus.rf_sa    = 1'b0;
    bus.rf_sb    = 1'b0;
    bus.rf_da    = 1'b0;
    bus.rf_w     = 1'b0;
    bus.rf_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_clear = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        busy       = 1'b1;
        bus.rom_en = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        load_ir = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy      = 1'b1;
        state_d   = S_FETCH;
        bus.rf_sa = ir_q[SRCA_BIT];
        bus.rf_sb = ir_q[SRCB_BIT];
        bus.rf_da = ir_q[DST_BIT];
        unique case (opcode)
          OP_LDI: begin
            bus.rf_w = 1'b1;
            bus.rf_d = imm;
            z_we     = 1'b1;
            z_d      = (imm == '0);
          end
          OP_MOV: begin
            bus.rf_w = 1'b1;
            bus.rf_d = bus.rf_a;
            z_we     = 1'b1;
            z_d      = (bus.rf_a == '0);
          end
          OP_ADD, OP_SUB: begin
            bus.rf_w = 1'b1;
            bus.rf_d = alu_res;
            z_we     = 1'b1;
            z_d      = alu_zero;
            c_we     = 1'b1;
            c_d      = alu_carry;
          end
          OP_JMP:  pc_jump = 1'b1;
          OP_JZ:   pc_jump = flags_q[FLAG_Z];
          OP_HALT: state_d = S_HALTED;
          default: ;
        endcase
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) begin
          pc_clear    = 1'b1;
          flags_clear = 1'b1;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer with a behavioural ROM and register file.
module tb_rf_sequencer;

  logic clock;
  logic reset;
  logic start;
  logic zero_flag, carry_flag, busy, halted;

  rf_sequencer_if #(.ADDR_W(4)) bus ();

  rf_sequencer #(.ADDR_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .busy       (busy),
    .halted     (halted)
  );

  logic [7:0] rom [16];
  logic [3:0] rf  [2];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int s0;
  int log_da[$];
  int log_d[$];
  int log_cyc[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read ROM
  always @(posedge clock) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];

  // Two-entry register file, combinational reads
  always @(posedge clock) if (bus.rf_w) rf[bus.rf_da] <= bus.rf_d;
  assign bus.rf_a = rf[bus.rf_sa];
  assign bus.rf_b = rf[bus.rf_sb];

  // Record every write strobe mid-cycle
  always @(negedge clock) begin
    if (bus.rf_w) begin
      log_da.push_back(int'(bus.rf_da));
      log_d.push_back(int'(bus.rf_d));
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    s0 = cyc;
  endtask

  task automatic load_rom(input logic [7:0] p0, p1, p2, p3, p4, input logic [7:0] p7);
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3; rom[4] = p4; rom[7] = p7;
  endtask

  task automatic clear_log();
    log_da.delete();
    log_d.delete();
    log_cyc.delete();
  endtask

  task automatic check_writes(input string nm, input int n, input int da0, d0, da1, d1, da2, d2);
    int eda[3];
    int ed[3];
    eda = '{da0, da1, da2};
    ed  = '{d0, d1, d2};
    total++;
    if (log_d.size() !== n) begin
      bad++;
      $display("FAIL %s write count: got %0d want %0d", nm, log_d.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        total++;
        if (log_da[i] !== eda[i] || log_d[i] !== ed[i] || log_cyc[i] !== s0 + 2 + 3 * i) begin
          bad++;
          $display("FAIL %s write %0d: got da=%0d d=%0h cyc=%0d want da=%0d d=%0h cyc=%0d",
                   nm, i, log_da[i], log_d[i], log_cyc[i] - s0, eda[i], ed[i], 2 + 3 * i);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    #12;
    total++;
    if ({bus.rom_en, bus.rf_w, bus.rf_sa, bus.rf_sb, bus.rf_da, busy, halted, zero_flag, carry_flag} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0", {bus.rom_en, bus.rf_w, bus.rf_sa, bus.rf_sb, bus.rf_da, busy, halted, zero_flag, carry_flag});
    end
    total++;
    if (bus.rom_addr !== 4'h0 || bus.rf_d !== 4'h0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h d=%h want 0 0", bus.rom_addr, bus.rf_d);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(2);
    total++;
    if (busy !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL idle_wait: got busy=%b halted=%b want 0 0", busy, halted);
    end
  endtask

  task automatic test_ldi_add();
    load_rom(8'h25, 8'h33, 8'h64, 8'hE0, 8'h00, 8'h00);
    clear_log();
    pulse_start();
    total++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== 4'h0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL add_first_fetch: got en=%b addr=%h busy=%b want 1 0 1", bus.rom_en, bus.rom_addr, busy);
    end
    step(11);
    total++;
    if (halted !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL add_pre_halt: got halted=%b busy=%b want 0 1", halted, busy);
    end
    step(1);
    total++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL add_halt12: got halted=%b busy=%b want 1 0", halted, busy);
    end
    total++;
    if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      bad++;
      $display("FAIL add_flags: got Z=%b C=%b want 0 0", zero_flag, carry_flag);
    end
    check_writes("add", 3, 0, 5, 1, 3, 0, 8);
  endtask

  task automatic test_zero_jz();
    load_rom(8'h2F, 8'h31, 8'h64, 8'hC7, 8'h00, 8'hE0);
    clear_log();
    pulse_start();
    step(9);
    total++;
    if (zero_flag !== 1'b1 || carry_flag !== 1'b1) begin
      bad++;
      $display("FAIL jz_flags: got Z=%b C=%b want 1 1", zero_flag, carry_flag);
    end
    check_writes("jz", 3, 0, 15, 1, 1, 0, 0);
    step(3);
    total++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== 4'h7) begin
      bad++;
      $display("FAIL jz_taken: got en=%b addr=%h want 1 7", bus.rom_en, bus.rom_addr);
    end
    step(3);
    total++;
    if (halted !== 1'b1 || zero_flag !== 1'b1) begin
      bad++;
      $display("FAIL jz_halt: got halted=%b Z=%b want 1 1", halted, zero_flag);
    end
  endtask

  task automatic test_restart_borrow();
    load_rom(8'h23, 8'h35, 8'h84, 8'hC7, 8'hE0, 8'h00);
    clear_log();
    pulse_start();
    total++;
    if (zero_flag !== 1'b0 || carry_flag !== 1'b0 || bus.rom_addr !== 4'h0 || bus.rom_en !== 1'b1) begin
      bad++;
      $display("FAIL restart: got Z=%b C=%b addr=%h en=%b want 0 0 0 1", zero_flag, carry_flag, bus.rom_addr, bus.rom_en);
    end
    step(9);
    total++;
    if (zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
      bad++;
      $display("FAIL borrow_flags: got Z=%b C=%b want 0 1", zero_flag, carry_flag);
    end
    check_writes("borrow", 3, 0, 3, 1, 5, 0, 14);
    step(3);
    total++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== 4'h4) begin
      bad++;
      $display("FAIL jz_untaken: got en=%b addr=%h want 1 4", bus.rom_en, bus.rom_addr);
    end
    step(3);
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL borrow_halt: got halted=%b want 1", halted);
    end
  endtask

  task automatic test_busy_start();
    load_rom(8'h25, 8'h33, 8'h64, 8'hE0, 8'h00, 8'h00);
    clear_log();
    pulse_start();
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    total++;
    if (bus.rom_addr !== 4'h2 || bus.rom_en !== 1'b1) begin
      bad++;
      $display("FAIL busy_start: got addr=%h en=%b want 2 1", bus.rom_addr, bus.rom_en);
    end
    step(6);
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL busy_halt: got halted=%b want 1", halted);
    end
    check_writes("busy", 3, 0, 5, 1, 3, 0, 8);
  endtask

  task automatic test_nop_wrap();
    load_rom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    clear_log();
    pulse_start();
    for (int k = 0; k < 18; k++) begin
      total++;
      if (bus.rom_addr !== 4'(k % 16) || bus.rom_en !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL nop_fetch%0d: got addr=%h en=%b busy=%b want %h 1 1", k, bus.rom_addr, bus.rom_en, busy, k % 16);
      end
      step(3);
    end
    total++;
    if (log_d.size() !== 0) begin
      bad++;
      $display("FAIL nop_writes: got %0d want 0", log_d.size());
    end
  endtask

  task automatic test_reset_mid_exec();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step(1);
    load_rom(8'h30, 8'h3A, 8'h00, 8'h00, 8'h00, 8'h00);
    clear_log();
    pulse_start();
    step(5);
    total++;
    if (bus.rf_w !== 1'b1 || bus.rf_d !== 4'hA || zero_flag !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_exec: got w=%b d=%h Z=%b want 1 a 1", bus.rf_w, bus.rf_d, zero_flag);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.rf_w, busy, bus.rom_en, zero_flag, carry_flag, halted} !== 6'b0 || bus.rom_addr !== 4'h0 || bus.rf_d !== 4'h0) begin
      bad++;
      $display("FAIL async_reset: got w/busy/en/Z/C/h=%b addr=%h d=%h want 0 0 0",
               {bus.rf_w, busy, bus.rom_en, zero_flag, carry_flag, halted}, bus.rom_addr, bus.rf_d);
    end
    @(posedge clock);
    #1;
    total++;
    if (rf[1] !== 4'h0) begin
      bad++;
      $display("FAIL reset_no_write: got r1=%h want 0", rf[1]);
    end
    reset = 1'b0;
    step(2);
    total++;
    if (busy !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b halted=%b want 0 0", busy, halted);
    end
    pulse_start();
    total++;
    if (bus.rom_addr !== 4'h0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_start: got addr=%h busy=%b want 0 1", bus.rom_addr, busy);
    end
  endtask

  initial begin
    rf[0] = 4'h0;
    rf[1] = 4'h0;
    test_reset();
    test_ldi_add();
    test_zero_jz();
    test_restart_borrow();
    test_busy_start();
    test_nop_wrap();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
